uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one `txd` UART transmitter among N byte requesters. Runs on the transmitter's bit clock. It sequences the transmitter's `c`/`send`/`avail` handshake: latches the winning byte, issues a one-clock `send` pulse, tracks the frame to completion and then reports back to the owner. It also detects a transmitter that never acknowledges, and enforces an optional extra stop-bit gap between frames.

---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N byte requesters.
// Sequences the transmitter's c/send/avail handshake, flags a stuck transmitter, adds an optional stop gap.
module uart_tx_arbiter #(
  parameter int N            = 4,
  parameter int BUSY_TIMEOUT = 4,
  parameter int GAP_CYCLES   = 1
) (
  input  logic             clk_9600Hz,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   data,
  output logic [N-1:0]     ack,
  output logic [N-1:0]     done,
  output logic [7:0]       tx_c,
  output logic             tx_send,
  input  logic             tx_avail,
  output logic             busy,
  output logic             err
);

  localparam int PW       = (N > 1) ? $clog2(N) : 1;
  localparam int TW       = $clog2(BUSY_TIMEOUT) + 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n, owner, owner_n, win;
  logic [TW-1:0]   timer, timer_n;
  logic [3:0]      gcnt, gcnt_n;
  logic [7:0]      tx_c_n;
  logic            tx_send_n, busy_n, err_n, found;
  logic [N-1:0]    ack_n, done_n;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (int'(v) == N - 1) ? '0 : v + PW'(1);
  endfunction

  // First requester at or after ptr, wrapping modulo N (also for non-power-of-2 N).
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_w;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      idx_w = PW'(idx);
      if (!found && req[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    owner_n   = owner;
    timer_n   = timer;
    gcnt_n    = gcnt;
    tx_c_n    = tx_c;
    tx_send_n = 1'b0;
    ack_n     = '0;
    done_n    = '0;
    err_n     = 1'b0;
    busy_n    = busy;
    case (state)
      IDLE: begin
        // tx_avail gate also covers a transmitter still finishing a frame begun before reset.
        if (tx_avail && found) begin
          tx_c_n     = data[{win, 3'b000} +: 8];
          owner_n    = win;
          ack_n[win] = 1'b1;
          busy_n     = 1'b1;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        tx_send_n = 1'b1;
        timer_n   = '0;
        state_n   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_avail) begin
          state_n = WAIT_DONE;
        end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
          err_n   = 1'b1;
          busy_n  = 1'b0;
          ptr_n   = wrap_inc(owner);
          state_n = IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_avail) begin
          done_n[owner] = 1'b1;
          ptr_n         = wrap_inc(owner);
          if (GAP_CYCLES > 0) begin
            gcnt_n  = '0;
            state_n = GAP;
          end else begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end
      end
      GAP: begin
        if (gcnt == 4'(GAP_LAST)) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          gcnt_n = gcnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_9600Hz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      timer   <= '0;
      gcnt    <= '0;
      tx_c    <= 8'h00;
      tx_send <= 1'b0;
      ack     <= '0;
      done    <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      timer   <= timer_n;
      gcnt    <= gcnt_n;
      tx_c    <= tx_c_n;
      tx_send <= tx_send_n;
      ack     <= ack_n;
      done    <= done_n;
      err     <= err_n;
      busy    <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transmitter model, line receiver, and a transaction-level
// round-robin reference model with a scoreboard monitor decoupled from the stimulus.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int BT  = 4;
  localparam int GAP = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0]   ack, done;
  logic [7:0]     tx_c;
  logic           tx_send, busy, err;

  always #5 clk = ~clk;

  // Transmitter model: no reset, start bit on the edge that sees send, 8 data bits, then stop.
  logic       tx_avail = 1'b1, line = 1'b1, tbusy = 1'b0, stuck = 1'b0;
  logic [7:0] sh = '0;
  logic [3:0] bitn = '0;

  uart_tx_arbiter #(.N(N), .BUSY_TIMEOUT(BT), .GAP_CYCLES(GAP)) dut (
    .clk_9600Hz(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack), .done(done),
    .tx_c(tx_c), .tx_send(tx_send), .tx_avail(tx_avail), .busy(busy), .err(err)
  );

  always @(posedge clk) begin
    if (tbusy) begin
      if (bitn < 4'd8) begin
        line <= sh[bitn[2:0]];
        bitn <= bitn + 4'd1;
      end else begin
        line     <= 1'b1;
        tx_avail <= 1'b1;
        tbusy    <= 1'b0;
      end
    end else if (tx_send && !stuck) begin
      tbusy    <= 1'b1;
      sh       <= tx_c;
      bitn     <= '0;
      line     <= 1'b0;
      tx_avail <= 1'b0;
    end
  end

  int   asserts = 0, fails = 0, cyc = 0, ptr_m = 0;
  logic [7:0] q_line[$];
  int   ack_log[$];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    asserts++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // Monitor + reference model: grants decided from the request vector seen at the edge.
  initial begin
    logic [N-1:0]   p_req;
    logic [8*N-1:0] p_data;
    logic           p_avail, p_busy, exp_g, inflight, stuck_g, exp_busy, d_exp, e_exp, fnd;
    int             w, ack_cyc, gap_end, sends, hold_bad, cur_owner;
    logic [7:0]     cur_byte;
    p_req = '0; p_data = '0; p_avail = 1'b1; p_busy = 1'b0;
    inflight = 1'b0; stuck_g = 1'b0; exp_busy = 1'b0;
    w = 0; ack_cyc = 0; gap_end = -1; sends = 0; hold_bad = 0; cur_owner = 0; cur_byte = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        inflight = 1'b0; exp_busy = 1'b0; ptr_m = 0; gap_end = -1;
      end else begin
        exp_g = !p_busy && p_avail && (p_req != '0);
        fnd = 1'b0;
        w = 0;
        for (int k = 0; k < N; k++)
          if (!fnd && p_req[(ptr_m + k) % N]) begin fnd = 1'b1; w = (ptr_m + k) % N; end
        if (exp_g || ack != '0) chk("ack", 32'(ack), exp_g ? (32'd1 << w) : 32'd0);
        for (int k = 0; k < N; k++) if (ack[k]) ack_log.push_back(k);
        if (exp_g) begin
          inflight = 1'b1; cur_owner = w; cur_byte = p_data[8*w +: 8]; ack_cyc = cyc;
          sends = 0; hold_bad = 0; stuck_g = stuck; exp_busy = 1'b1;
          if (!stuck) q_line.push_back(cur_byte);
        end
        if (tx_send) begin
          if (inflight) chk("send_time", cyc, ack_cyc + 1);
          else chk("send_spurious", 1, 0);
          sends++;
        end
        if (inflight && tx_c !== cur_byte) hold_bad++;
        d_exp = inflight && !stuck_g && (cyc == ack_cyc + 12);
        e_exp = inflight && stuck_g && (cyc == ack_cyc + 1 + BT);
        if (d_exp || done != '0) chk("done", 32'(done), d_exp ? (32'd1 << cur_owner) : 32'd0);
        if (e_exp || err) chk("err", 32'(err), 32'(e_exp));
        if (d_exp || e_exp) begin
          chk("send_count", sends, 1);
          chk("tx_c_hold", hold_bad, 0);
          ptr_m = (cur_owner + 1) % N;
          inflight = 1'b0;
          if (e_exp || GAP == 0) exp_busy = 1'b0;
          else gap_end = cyc + GAP;
        end
        if (cyc == gap_end) exp_busy = 1'b0;
        if (inflight && cyc > ack_cyc + 40) begin
          chk("frame_timeout", 0, 1);
          inflight = 1'b0; exp_busy = 1'b0;
        end
        chk("busy", 32'(busy), 32'(exp_busy));
      end
      p_req = req; p_data = data; p_avail = tx_avail; p_busy = busy;
    end
  end

  // Line receiver: decodes start, 8 LSB-first bits, stop.
  initial begin
    logic [7:0] b, e;
    b = '0;
    forever begin
      @(negedge clk);
      if (line == 1'b0) begin
        for (int i = 0; i < 8; i++) begin @(negedge clk); b[i] = line; end
        @(negedge clk);
        chk("stop_bit", 32'(line), 1);
        if (q_line.size() == 0) chk("line_unexpected", 0, 1);
        else begin e = q_line.pop_front(); chk("line_byte", 32'(b), 32'(e)); end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_acks(input int n);
    int t = 0;
    while (ack_log.size() < n && t < 300) begin step(); t++; end
    if (ack_log.size() < n) chk("ack_wait_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin step(); t++; end
    while (!(busy == 1'b0 && tx_avail && !tbusy && line) && t < 300);
    if (t >= 300) chk("idle_wait_timeout", 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_send"}, 32'(tx_send), 0);
    chk({tag, "_tx_c"}, 32'(tx_c), 0);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rst");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    step();

    // Round-robin with all requesting, starting from ptr 0.
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    ack_log.delete();
    req = 4'b1111;
    wait_acks(4);
    req = '0;
    wait_idle();
    for (int i = 0; i < 4; i++) chk("rr_order", ack_log[i], i);

    // Priority rotation: ptr wrapped to 0 after serving 3.
    ack_log.delete();
    req = 4'b1001;
    wait_acks(2);
    req = '0;
    wait_idle();
    chk("rot_first", ack_log[0], 0);
    chk("rot_second", ack_log[1], 3);

    // Single request.
    ack_log.delete();
    data[23:16] = 8'hA5;
    req = 4'b0100;
    wait_acks(1);
    req = '0;
    wait_idle();
    chk("single_owner", ack_log[0], 2);

    // Transmitter never acknowledges.
    stuck = 1'b1;
    ack_log.delete();
    req = 4'b0010;
    wait_acks(1);
    req = '0;
    wait_idle();
    stuck = 1'b0;
    req = 4'b0001;
    wait_acks(2);
    req = '0;
    wait_idle();
    chk("after_timeout_owner", ack_log[1], 0);

    // Reset during data bit 4; request held.
    ack_log.delete();
    data[23:16] = 8'h3C;
    req = 4'b0100;
    wait_acks(1);
    repeat (6) step();
    rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    step();
    rst_n = 1'b1;
    wait_acks(2);
    req = '0;
    wait_idle();
    chk("midrst_regrant", ack_log[1], 2);

    // Random requests and data changing every clock.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) req = N'($urandom);
      for (int i = 0; i < N; i++) data[8*i +: 8] = 8'($urandom);
      step();
    end
    req = '0;
    wait_idle();
    repeat (4) step();
    chk("line_queue_empty", q_line.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
